// File: rtl/ram_16_pkg.sv
// Shared constants and types for the ram_16 64K x 8 byte store.
package ram_16_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1 << ADDR_W;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/ram_16_array.sv
// Raw storage array for ram_16: one write port, one read port, no reset,
// so the memory itself stays free of per-word control logic.
module ram_16_array
  import ram_16_pkg::*;
(
  input  logic  clk,
  input  logic  we,
  input  addr_t wr_addr,
  input  data_t wr_data,
  input  addr_t rd_addr,
  output data_t rd_data
);

  data_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  // Read returns the contents as of before this edge, giving read-first behaviour.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ram_16.sv
// 64K x 8 RAM with independent write/read addresses and a registered read.
// Optional macro RAM16_BYPASS_EN selects write-first on same-address collisions.
module ram_16
  import ram_16_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] in_address,
  input  logic [ADDR_W-1:0] out_address,
  input  logic [DATA_W-1:0] in_data,
  output logic [DATA_W-1:0] out_data
);

  // One valid bit per word masks stale array contents after reset.
  logic [DEPTH-1:0] valid;
  data_t            rd_data;
  logic             wr_en;
  logic             bypass_hit;

  assign wr_en = we & ~rst;

  ram_16_array u_array (
    .clk     (clk),
    .we      (wr_en),
    .wr_addr (in_address),
    .wr_data (in_data),
    .rd_addr (out_address),
    .rd_data (rd_data)
  );

`ifdef RAM16_BYPASS_EN
  assign bypass_hit = we && (in_address == out_address);
`else
  assign bypass_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      valid    <= '0;
      out_data <= '0;
    end else begin
      if (we) valid[in_address] <= 1'b1;
      if (bypass_hit)
        out_data <= in_data;
      else
        out_data <= valid[out_address] ? rd_data : '0;
    end
  end

endmodule

// File: tb/tb_ram_16.sv
// Self-checking bench for ram_16: directed vector table, hand-written
// reset/hold sequences, and randomized traffic against a sparse-memory model.
module tb_ram_16;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [15:0] in_address;
  logic [15:0] out_address;
  logic [7:0]  in_data;
  logic [7:0]  out_data;

  int total = 0;
  int bad   = 0;

`ifdef RAM16_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  localparam logic [7:0] COLLIDE_EXP = BYPASS ? 8'd9 : 8'd7;

  ram_16 dut (
    .clk         (clk),
    .rst         (rst),
    .we          (we),
    .in_address  (in_address),
    .out_address (out_address),
    .in_data     (in_data),
    .out_data    (out_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [15:0] ia;
    logic [15:0] oa;
    logic [7:0]  d;
    logic [7:0]  exp;
    string       name;
  } vec_t;

  vec_t vecs [17];

  // Reference model: only written addresses exist; a missing key reads as zero.
  logic [7:0] mdl [int];

  function automatic logic [7:0] stepModel(input logic r, input logic w,
                                           input logic [15:0] ia, input logic [15:0] oa,
                                           input logic [7:0] d);
    logic [7:0] res;
    if (r) begin
      mdl.delete();
      return 8'd0;
    end
    if (w && BYPASS && ia == oa) res = d;
    else if (mdl.exists(int'(oa))) res = mdl[int'(oa)];
    else res = 8'd0;
    if (w) mdl[int'(ia)] = d;
    return res;
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] exp);
    total++;
    if (out_data !== exp) begin
      bad++;
      $display("[TB] FAIL %s: out_data=%0d expected=%0d at %0t", name, out_data, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, take the edge, then sample just after it.
  task automatic applyStimulus(input logic r, input logic w, input logic [15:0] ia,
                               input logic [15:0] oa, input logic [7:0] d);
    rst = r; we = w; in_address = ia; out_address = oa; in_data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp;
    rst = 1'b1; we = 1'b0; in_address = '0; out_address = '0; in_data = '0;

    vecs[0]  = '{1, 1,     5,    28,   3, 8'd0,        "reset_edge"};
    vecs[1]  = '{0, 0,     0,    28,   0, 8'd0,        "read_after_reset"};
    vecs[2]  = '{0, 1, 51524,     0,  45, 8'd0,        "write_51524"};
    vecs[3]  = '{0, 1,   784, 51524, 124, 8'd45,       "read_51524"};
    vecs[4]  = '{0, 0,     0,   784,   0, 8'd124,      "read_784"};
    vecs[5]  = '{0, 0,     0,    24,   0, 8'd0,        "unwritten_24"};
    vecs[6]  = '{0, 1,    14,    24, 124, 8'd0,        "write_14"};
    vecs[7]  = '{0, 0,     0,    14,   0, 8'd124,      "read_14"};
    vecs[8]  = '{0, 1,   100, 51524,   7, 8'd45,       "write_100_7"};
    vecs[9]  = '{0, 1,   100,   100,   9, COLLIDE_EXP, "collide_100"};
    vecs[10] = '{0, 0,     0,   100,   0, 8'd9,        "after_collide"};
    vecs[11] = '{0, 0, 51524, 51524, 200, 8'd45,       "we0_same_cycle"};
    vecs[12] = '{0, 0,     0, 51524,   0, 8'd45,       "we0_hold"};
    vecs[13] = '{1, 1,     5, 51524,   3, 8'd0,        "mid_reset"};
    vecs[14] = '{0, 0,     0, 51524,   0, 8'd0,        "post_rst_51524"};
    vecs[15] = '{0, 0,     0,   784,   0, 8'd0,        "post_rst_784"};
    vecs[16] = '{0, 0,     0,     5,   0, 8'd0,        "post_rst_5"};

    @(negedge clk);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].rst, vecs[i].we, vecs[i].ia, vecs[i].oa, vecs[i].d);
      checkOutput(vecs[i].name, vecs[i].exp);
      void'(stepModel(vecs[i].rst, vecs[i].we, vecs[i].ia, vecs[i].oa, vecs[i].d));
    end

    // Reset held over several cycles with writes attempted: output stays 0, nothing lands.
    applyStimulus(0, 1, 16'd300, 16'd0, 8'd55);
    void'(stepModel(0, 1, 16'd300, 16'd0, 8'd55));
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 1, 16'd300, 16'd300, 8'd77);
      void'(stepModel(1, 1, 16'd300, 16'd300, 8'd77));
      checkOutput("held_reset", 8'd0);
    end
    applyStimulus(0, 0, 16'd0, 16'd300, 8'd0);
    void'(stepModel(0, 0, 16'd0, 16'd300, 8'd0));
    checkOutput("write_during_rst_dropped", 8'd0);

    // Boundary addresses, and out_data holding steady between edges.
    applyStimulus(0, 1, 16'hFFFF, 16'd0, 8'hA5);
    void'(stepModel(0, 1, 16'hFFFF, 16'd0, 8'hA5));
    applyStimulus(0, 1, 16'h0000, 16'hFFFF, 8'h5A);
    void'(stepModel(0, 1, 16'h0000, 16'hFFFF, 8'h5A));
    checkOutput("read_top_addr", 8'hA5);
    out_address = 16'h0000;
    #3;
    checkOutput("hold_between_edges", 8'hA5);
    applyStimulus(0, 0, 16'd0, 16'h0000, 8'd0);
    void'(stepModel(0, 0, 16'd0, 16'h0000, 8'd0));
    checkOutput("read_addr_0", 8'h5A);

    // Random traffic over a small address pool at both ends, so collisions and rewrites are common.
    for (int i = 0; i < 400; i++) begin
      logic        r, w;
      logic [15:0] ia, oa;
      logic [7:0]  d;
      int          pi, po;
      r  = ($urandom_range(0, 39) == 0);
      w  = $urandom_range(0, 1);
      pi = $urandom_range(0, 15);
      po = $urandom_range(0, 15);
      ia = (pi < 8) ? 16'(pi) : 16'(65528 + pi - 8);
      oa = (po < 8) ? 16'(po) : 16'(65528 + po - 8);
      d  = 8'($urandom);
      exp = stepModel(r, w, ia, oa, d);
      applyStimulus(r, w, ia, oa, d);
      checkOutput("random", exp);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
